// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks the PC, keeps one memory request in flight,
// and queues returned instructions with their PCs for the decoder.
module fetch_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] entry_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  output logic        halted,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);
  localparam logic [31:0] ECALL    = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [63:0]   pc_r, pc_nxt_s;
  logic [63:0]   req_pc_r, req_pc_nxt_s;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [63:0]   pc_mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s, flush_s, pop_s, hs_s;
  logic [63:0]   entry_al_s, redir_al_s;

  assign entry_al_s    = {entry_pc[63:2], 2'b00};
  assign redir_al_s    = {redirect_pc[63:2], 2'b00};
  assign mem_req_valid = (state_r == S_REQ) && (count_r < FULL_CNT);
  assign mem_req_addr  = pc_r;
  assign dec_valid     = (count_r != ZERO_CNT);
  assign dec_instr     = instr_mem_r[rd_ptr_r];
  assign dec_pc        = pc_mem_r[rd_ptr_r];
  assign halted        = (state_r == S_HALT);
  assign busy          = ((state_r != S_IDLE) && (state_r != S_HALT)) || dec_valid;
  assign hs_s          = mem_req_valid && mem_req_ready;
  assign pop_s         = dec_valid && dec_ready;

  // Next-state, PC and FIFO-control decode
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    req_pc_nxt_s = req_pc_r;
    push_s       = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          pc_nxt_s    = entry_al_s;
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        // A request accepted alongside a redirect is still in flight: drain it
        if (redirect_valid) begin
          pc_nxt_s    = redir_al_s;
          flush_s     = 1'b1;
          state_nxt_s = hs_s ? S_DRAIN : S_REQ;
        end else if (hs_s) begin
          req_pc_nxt_s = pc_r;
          state_nxt_s  = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt_s    = redir_al_s;
          flush_s     = 1'b1;
          state_nxt_s = mem_resp_valid ? S_REQ : S_DRAIN;
        end else if (mem_resp_valid) begin
          push_s      = 1'b1;
          pc_nxt_s    = req_pc_r + 64'd4;
          state_nxt_s = (mem_resp_data == ECALL) ? S_HALT : S_REQ;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          pc_nxt_s = redir_al_s;
          flush_s  = 1'b1;
        end else begin
          pc_nxt_s = pc_r;
        end
        state_nxt_s = mem_resp_valid ? S_REQ : S_DRAIN;
      end
      S_HALT: begin
        if (start) begin
          pc_nxt_s    = entry_al_s;
          state_nxt_s = S_REQ;
        end else if (redirect_valid) begin
          pc_nxt_s    = redir_al_s;
          flush_s     = 1'b1;
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_HALT;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      pc_r     <= 64'd0;
      req_pc_r <= 64'd0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      req_pc_r <= req_pc_nxt_s;
    end
  end

  // Instruction queue; entries are cleared on reset so the head reads zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_CNT;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'd0;
        pc_mem_r[i]    <= 64'd0;
      end
    end else if (flush_s) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= mem_resp_data;
        pc_mem_r[wr_ptr_r]    <= req_pc_r;
        wr_ptr_r              <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: transaction-level model (flags plus
// an instruction queue), a latency-randomised memory, directed and random phases.
module tb_fetch_sequencer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b0, mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic        redirect_valid = 1'b0, dec_ready = 1'b0;
  logic [63:0] entry_pc = 64'd0, redirect_pc = 64'd0;
  logic [31:0] mem_resp_data = 32'd0;
  logic        mem_req_valid, dec_valid, halted, busy;
  logic [63:0] mem_req_addr, dec_pc;
  logic [31:0] dec_instr;

  always #5 clk = ~clk;

  fetch_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .halted(halted), .busy(busy)
  );

  typedef struct packed { logic [31:0] instr; logic [63:0] pc; } ent_t;

  ent_t        fq[$];    // model queue contents
  ent_t        got[$];   // instructions the decoder actually took
  logic [63:0] reqs[$];  // addresses of accepted requests
  bit          m_run, m_out, m_disc, m_halt;
  logic [63:0] m_pc, m_req_pc;
  int          tmr = 0, lat_fix = 1;
  logic [31:0] resp_d = 32'd0;
  logic [63:0] ecall_addr = 64'hFFFF_FFFF_FFFF_FFFF;
  bit          rand_ecall = 1'b0;
  int          checks = 0, failures = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[17:2], a[15:0] ^ 16'hA5C3};
  endfunction

  function automatic logic [63:0] al(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

  function automatic bit m_req_valid();
    return m_run && !m_out && (fq.size() < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: REQ = running & no request out; WAIT = out; DRAIN = out & discard
  task automatic model_step();
    bit hs;
    if (!reset) begin
      m_run = 0; m_out = 0; m_disc = 0; m_halt = 0;
      m_pc = 64'd0; m_req_pc = 64'd0; fq.delete();
      return;
    end
    hs = m_req_valid() && mem_req_ready;
    if (fq.size() != 0 && dec_ready) void'(fq.pop_front());
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_halt = 0; m_pc = al(entry_pc);
      end else if (m_halt && redirect_valid) begin
        m_run = 1; m_halt = 0; m_pc = al(redirect_pc); fq.delete();
      end
    end else if (!m_out) begin
      if (redirect_valid) begin
        m_pc = al(redirect_pc); fq.delete();
        if (hs) begin m_out = 1; m_disc = 1; end
      end else if (hs) begin
        m_req_pc = m_pc; m_out = 1; m_disc = 0;
      end
    end else if (!m_disc) begin
      if (redirect_valid) begin
        m_pc = al(redirect_pc); fq.delete();
        if (mem_resp_valid) m_out = 0; else m_disc = 1;
      end else if (mem_resp_valid) begin
        fq.push_back({mem_resp_data, m_req_pc});
        m_pc = m_req_pc + 64'd4; m_out = 0;
        if (mem_resp_data == ECALL) begin m_run = 0; m_halt = 1; end
      end
    end else begin
      if (redirect_valid) begin m_pc = al(redirect_pc); fq.delete(); end
      if (mem_resp_valid) begin m_out = 0; m_disc = 0; end
    end
  endtask

  task automatic compare();
    chk("mem_req_valid", mem_req_valid, m_req_valid());
    if (m_req_valid()) chk("mem_req_addr", mem_req_addr, m_pc);
    chk("dec_valid", dec_valid, fq.size() != 0);
    if (fq.size() != 0) begin
      chk("dec_instr", dec_instr, fq[0].instr);
      chk("dec_pc", dec_pc, fq[0].pc);
    end
    chk("halted", halted, m_halt);
    chk("busy", busy, m_run || fq.size() != 0);
  endtask

  // One clock: log handshakes, schedule memory, advance model, check outputs
  task automatic tick();
    if (reset && mem_req_valid && mem_req_ready) reqs.push_back(mem_req_addr);
    if (reset && dec_valid && dec_ready) got.push_back({dec_instr, dec_pc});
    if (reset && m_req_valid() && mem_req_ready) begin
      tmr = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
      resp_d = (m_pc == ecall_addr || (rand_ecall && $urandom_range(0, 11) == 0)) ? ECALL : mem_word(m_pc);
    end
    model_step();
    @(posedge clk);
    #1;
    start = 1'b0;
    redirect_valid = 1'b0;
    if (tmr > 0) begin tmr--; mem_resp_valid = (tmr == 0); end
    else mem_resp_valid = 1'b0;
    mem_resp_data = mem_resp_valid ? resp_d : $urandom;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    got.delete(); reqs.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_valid"}, mem_req_valid, 64'd0);
    chk({tag, "_req_addr"}, mem_req_addr, 64'd0);
    chk({tag, "_dec_valid"}, dec_valid, 64'd0);
    chk({tag, "_dec_instr"}, dec_instr, 64'd0);
    chk({tag, "_dec_pc"}, dec_pc, 64'd0);
    chk({tag, "_halted"}, halted, 64'd0);
    chk({tag, "_busy"}, busy, 64'd0);
  endtask

  task automatic launch(input logic [63:0] pc);
    start = 1'b1; entry_pc = pc;
    tick();
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (2) tick();
    check_zero_outputs("reset");

    // Basic fetch
    reset = 1'b1; mem_req_ready = 1'b1; dec_ready = 1'b1; lat_fix = 1;
    launch(64'h1000);
    chk("start_to_req", mem_req_valid, 64'd1);
    repeat (12) tick();
    chk("basic_count", got.size() >= 4, 64'd1);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("basic_pc", got[i].pc, 64'h1000 + 64'(4 * i));
      chk("basic_instr", got[i].instr, mem_word(64'h1000 + 64'(4 * i)));
    end

    // Backpressure: queue fills, fetch stops, then resumes at 0x1010
    do_reset();
    dec_ready = 1'b0;
    launch(64'h1000);
    repeat (14) tick();
    chk("bp_req_count", reqs.size(), 64'd4);
    chk("bp_req_stalled", mem_req_valid, 64'd0);
    dec_ready = 1'b1;
    repeat (12) tick();
    chk("bp_drained", got.size() >= 4, 64'd1);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("bp_pc", got[i].pc, 64'h1000 + 64'(4 * i));
    chk("bp_resume_n", reqs.size() >= 5, 64'd1);
    if (reqs.size() >= 5) chk("bp_resume_addr", reqs[4], 64'h1010);

    // Redirect while waiting on a slow response
    do_reset();
    lat_fix = 3;
    launch(64'h1000);
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    tick();
    chk("rw_dec_valid", dec_valid, 64'd0);
    repeat (12) tick();
    chk("rw_req_n", reqs.size() >= 2, 64'd1);
    if (reqs.size() >= 2) chk("rw_next_addr", reqs[1], 64'h2000);
    chk("rw_got_n", got.size() >= 1, 64'd1);
    if (got.size() >= 1) chk("rw_first_pc", got[0].pc, 64'h2000);

    // Redirect coinciding with the response
    do_reset();
    lat_fix = 2;
    launch(64'h1000);
    for (int i = 0; i < 8 && !mem_resp_valid; i++) tick();
    chk("rs_resp_seen", mem_resp_valid, 64'd1);
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    chk("rs_req_valid", mem_req_valid, 64'd1);
    chk("rs_req_addr", mem_req_addr, 64'h3000);
    chk("rs_dec_valid", dec_valid, 64'd0);
    repeat (6) tick();
    chk("rs_got_n", got.size() >= 1, 64'd1);
    if (got.size() >= 1) chk("rs_first_pc", got[0].pc, 64'h3000);

    // ECALL halts fetch; start relaunches
    do_reset();
    lat_fix = 1; ecall_addr = 64'h100C;
    launch(64'h1000);
    repeat (16) tick();
    chk("ec_got_n", got.size(), 64'd4);
    if (got.size() == 4) begin
      chk("ec_instr", got[3].instr, ECALL);
      chk("ec_pc", got[3].pc, 64'h100C);
    end
    chk("ec_halted", halted, 64'd1);
    chk("ec_req_n", reqs.size(), 64'd4);
    ecall_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    launch(64'h4000);
    chk("ec_restart_valid", mem_req_valid, 64'd1);
    chk("ec_restart_addr", mem_req_addr, 64'h4000);
    chk("ec_restart_halted", halted, 64'd0);

    // Reset while waiting with two queued entries
    do_reset();
    dec_ready = 1'b0; lat_fix = 3;
    launch(64'h1000);
    for (int i = 0; i < 40 && !(fq.size() == 2 && m_out && !m_disc); i++) tick();
    chk("rm_reached_wait", fq.size() == 2 && m_out && !m_disc, 64'd1);
    chk("rm_dec_valid_pre", dec_valid, 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_zero_outputs("rm");
    repeat (4) tick();
    chk("rm_late_dec_valid", dec_valid, 64'd0);
    chk("rm_late_busy", busy, 64'd0);

    // Random phase
    do_reset();
    lat_fix = 0; rand_ecall = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 299) != 0);
      start          = (tmr == 0) && ($urandom_range(0, 7) == 0);
      entry_pc       = {48'd0, 16'($urandom)};
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = {48'd0, 16'($urandom)};
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
